// File: rtl/lfsr_pkg.sv
// Shared constants and types for the lfsr_rng random source.
// Defaults give a maximal-length 16-bit sequence (period 65535).
package lfsr_pkg;

  localparam int                    LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED  = 16'hECEB;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 16'h002D;

  typedef logic [LFSR_WIDTH-1:0] lfsr_state_t;

endpackage : lfsr_pkg

// File: rtl/lfsr_feedback.sv
// Feedback bit for the LFSR: the parity of the state bits selected by the tap mask.
// Purely combinational; the caller owns all state.
module lfsr_feedback #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAP_MASK = 16'h002D
) (
  input  logic [WIDTH-1:0] state,
  output logic             fb
);

  // XOR-reduce the tapped bits
  always_comb begin
    fb = ^(state & TAP_MASK);
  end

endmodule : lfsr_feedback

// File: rtl/lfsr_rng.sv
// Fibonacci right-shifting LFSR random source.
// One step per rising clk edge while en is high: the LSB is shifted out into
// rand_bit and the feedback bit enters at the MSB. Both outputs are registered.
// Optional feature macro: LFSR_SEED_LOAD_EN adds load/load_val, a seed reload
// that takes priority over en; a zero load value is replaced by SEED so the
// register can never lock up in the all-zero state.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(LFSR_SEED),
  parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(LFSR_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef LFSR_SEED_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`endif
  output logic             rand_bit,
  output logic [WIDTH-1:0] shift_reg
);

  logic fb;

  lfsr_feedback #(
    .WIDTH    (WIDTH),
    .TAP_MASK (TAP_MASK)
  ) u_feedback (
    .state (shift_reg),
    .fb    (fb)
  );

`ifdef LFSR_SEED_LOAD_EN
  logic [WIDTH-1:0] load_state;

  // Substitute SEED for a zero load value to keep the state out of lock-up
  always_comb begin
    load_state = load_val;
    if (load_val == '0) begin
      load_state = SEED;
    end
  end
`endif

  // State and output-bit registers: reset > load (optional) > advance > hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= SEED;
      rand_bit  <= 1'b0;
    end else begin
`ifdef LFSR_SEED_LOAD_EN
      if (load) begin
        shift_reg <= load_state;
        rand_bit  <= 1'b0;
      end else
`endif
      if (en) begin
        rand_bit  <= shift_reg[0];
        shift_reg <= {fb, shift_reg[WIDTH-1:1]};
      end
    end
  end

endmodule : lfsr_rng

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng (default 16-bit configuration).
// The driver pushes the expected {rand_bit, shift_reg} for every cycle it drives;
// the monitor pops and compares shortly after each rising edge.
// Directed checks against hand-computed constants cover reset, the first steps,
// hold, wrap-around, asynchronous reset and (with LFSR_SEED_LOAD_EN) seed loading.
module tb_lfsr_rng;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        rand_bit;
  logic [15:0] shift_reg;
`ifdef LFSR_SEED_LOAD_EN
  logic        load     = 1'b0;
  logic [15:0] load_val = '0;
`endif

  int          checks     = 0;
  int          failures   = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_exp;
  logic [15:0] m_state    = 16'hECEB;
  logic        m_bit      = 1'b0;
  bit          period_active = 1'b0;
  int          seed_hits  = 0;
  int          zero_hits  = 0;

  // Clock and DUT
  always #5 clk = ~clk;

  lfsr_rng dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
`ifdef LFSR_SEED_LOAD_EN
    .load      (load),
    .load_val  (load_val),
`endif
    .rand_bit  (rand_bit),
    .shift_reg (shift_reg)
  );

  // Reference step with the default taps written out bit by bit: {out_bit, next_state}
  function automatic logic [16:0] ref_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {s[0], fb, s[15:1]};
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Drive one cycle of en and queue the expected outputs after that edge
  task automatic pulse(input logic en_v);
    @(negedge clk);
    en = en_v;
    if (en_v) begin
      {m_bit, m_state} = ref_step(m_state);
    end
    exp_q.push_back({m_bit, m_state});
  endtask

  // Return en low; the preceding edge's result is stable at this point
  task automatic settle();
    @(negedge clk);
    en = 1'b0;
  endtask

  // Assert reset between edges and confirm it takes effect without a clock edge
  task automatic async_reset(input string name);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check(name, {rand_bit, shift_reg}, {1'b0, 16'hECEB});
    @(negedge clk);
    rst_n   = 1'b1;
    m_state = 16'hECEB;
    m_bit   = 1'b0;
  endtask

`ifdef LFSR_SEED_LOAD_EN
  task automatic do_load(input logic [15:0] v, input logic en_v);
    @(negedge clk);
    load     = 1'b1;
    load_val = v;
    en       = en_v;
    m_state  = (v == 16'h0) ? 16'hECEB : v;
    m_bit    = 1'b0;
    exp_q.push_back({m_bit, m_state});
    @(negedge clk);
    load = 1'b0;
    en   = 1'b0;
  endtask
`endif

  // Monitor: compare every queued expectation just after the rising edge
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      check("seq", {rand_bit, shift_reg}, mon_exp);
      if (period_active) begin
        if (shift_reg == 16'hECEB) seed_hits++;
        if (shift_reg == 16'h0000) zero_hits++;
      end
    end
  end

  // Watchdog
  initial begin
    #1500000;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  // Main stimulus
  initial begin
    // Reset held for 4 cycles with en high: reset wins
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_hold", {rand_bit, shift_reg}, {1'b0, 16'hECEB});
    rst_n = 1'b1;
    en    = 1'b0;

    // First two steps
    pulse(1'b1);
    settle();
    check("step1", {rand_bit, shift_reg}, {1'b1, 16'hF675});
    pulse(1'b1);
    settle();
    check("step2", {rand_bit, shift_reg}, {1'b1, 16'hFB3A});

    // Hold for 10 cycles
    repeat (10) pulse(1'b0);
    settle();
    check("hold", {rand_bit, shift_reg}, {1'b1, 16'hFB3A});

    // Asynchronous reset between edges
    async_reset("async_rst");

    // Full period with occasional random gaps between enables
    period_active = 1'b1;
    for (int i = 1; i <= 65535; i++) begin
      pulse(1'b1);
      if (i != 65535 && (i % 64) == 0) begin
        repeat ($urandom_range(0, 3)) pulse(1'b0);
      end
    end
    settle();
    period_active = 1'b0;
    check("wrap", {1'b0, shift_reg}, {1'b0, 16'hECEB});
    check("seed_once", 17'(seed_hits), 17'd1);
    check("never_zero", 17'(zero_hits), 17'd0);

    // Reset after 1000 steps, then restart from step 0
    repeat (1000) pulse(1'b1);
    settle();
    async_reset("midrun_rst");
    pulse(1'b1);
    settle();
    check("restart_step1", {rand_bit, shift_reg}, {1'b1, 16'hF675});

`ifdef LFSR_SEED_LOAD_EN
    do_load(16'h1234, 1'b0);
    check("load_val", {rand_bit, shift_reg}, {1'b0, 16'h1234});
    do_load(16'h0000, 1'b0);
    check("load_zero", {rand_bit, shift_reg}, {1'b0, 16'hECEB});
    do_load(16'hBEEF, 1'b1);
    check("load_over_en", {rand_bit, shift_reg}, {1'b0, 16'hBEEF});
`endif

    repeat (2) @(negedge clk);
    check("drain", 17'(exp_q.size()), 17'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lfsr_rng

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
- Fibonacci-style right-shifting linear feedback shift register (LFSR) with a 16-bit default width.
- Produces one pseudo-random bit per enabled clock and exposes the full state.
- Used as a lightweight random source for arbitration and test stimulus inside the core.
- With default taps the sequence is maximal-length (period 2^16-1 = 65535).

Parameters:
- WIDTH, 16, register width in bits (>= 4).
- SEED, 16'hECEB, reset and reload value; must be nonzero.
- TAP_MASK, 16'h002D, feedback tap mask (bits 0, 2, 3, 5); feedback is the XOR of the state bits selected by the mask.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low. Assertion is immediate; release is synchronized by the integrator.
- en  input  1  advance enable; one shift per rising clk edge while high.
- rand_bit  output  1  bit shifted out by the most recent advance.
- shift_reg  output  WIDTH  current LFSR state.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - shift_reg = SEED (0xECEB).
  - rand_bit = 0.
- Advance, on a rising clk edge with en=1 and rst_n=1:
  - fb = ^(shift_reg & TAP_MASK); with the default mask, fb = s[0]^s[2]^s[3]^s[5].
  - rand_bit <= s[0].
  - shift_reg <= {fb, s[WIDTH-1:1]}.
- Hold: with en=0, both outputs keep their values indefinitely.
- Latency: outputs update on the same edge that samples en=1. Both are registered; there is no combinational path from en to the outputs.
- Enable pattern: back-to-back en=1 advances once per cycle. Arbitrary gaps between enables change nothing except the number of steps taken.
- Wrap-around: after exactly 65535 advances from SEED, shift_reg == SEED again. No intermediate state equals SEED, and the state is never 0.
- Lock-up: the all-zero state is unreachable from a nonzero seed. No zero-state detection is required in the base design.
- Reset mid-sequence: asynchronously restores SEED and rand_bit=0. The sequence restarts from step 0 on the next enabled edge.
- Simultaneous reset and en: reset wins.

Optional Feature:
- Macro: LFSR_SEED_LOAD_EN.
- When defined, two extra inputs are added: load (1 bit) and load_val (WIDTH bits).
- On a rising edge with load=1:
  - shift_reg <= load_val, or SEED if load_val == 0 (lock-up avoidance).
  - rand_bit <= 0.
- load has priority over en.
- When undefined, these ports do not exist and behaviour is exactly the base design.

Decomposition:
- Package lfsr_pkg holds:
  - LFSR_WIDTH = 16, LFSR_SEED = 16'hECEB, LFSR_TAPS = 16'h002D.
  - typedef lfsr_state_t (logic [LFSR_WIDTH-1:0]).
- One natural sub-module, lfsr_feedback: combinational parity of state & TAP_MASK, returning fb.
- The top module holds the state register, the rand_bit register and the optional load mux.

Test Plan:
- Reset: hold rst_n=0 for 4 cycles -> shift_reg=0xECEB, rand_bit=0. Drop rst_n mid-cycle -> outputs reset immediately, without waiting for an edge.
- Single step: one en pulse after reset -> shift_reg=0xF675, rand_bit=1. Second pulse -> shift_reg=0xFB3A, rand_bit=1.
- Hold: en=0 for 10 cycles after step 2 -> shift_reg stays 0xFB3A and rand_bit stays 1.
- Full period with random 0-3 cycle gaps between single-cycle en pulses:
  - Compare each step against a reference model.
  - After 65535 steps, shift_reg=0xECEB.
  - shift_reg never equals 0.
- Reset mid-run: reset after 1000 steps, then one en pulse -> shift_reg=0xF675, rand_bit=1.
- With LFSR_SEED_LOAD_EN:
  - load=1, load_val=0x1234 -> shift_reg=0x1234.
  - load_val=0 -> shift_reg=0xECEB.
  - load=1 with en=1 -> load wins.
